// File: rtl/modn_updown_counter.sv
// -----------------------------------------------------------------------------
// modn_updown_counter
//   Parametrised modulo-N up/down counter with count enable, synchronous
//   parallel load and cascade-ready status outputs.
//   The count runs over 0..MODULUS-1 and never leaves that range.
//
// Parameters
//   MODULUS   : count modulus N (2..2**WIDTH)
//   WIDTH     : width of the count and of the load value
//   RESET_VAL : value of d_out after reset (< MODULUS)
//
// Ports
//   clk      : clock; all state changes on its rising edge
//   reset    : synchronous, active-high reset
//   en       : count enable, one step per enabled cycle
//   up_dn    : direction, 1 = up, 0 = down
//   load     : synchronous load request (wins over en)
//   load_val : value written on load; values >= MODULUS are rejected
//   d_out    : registered count
//   tc       : combinational terminal count / carry-out; drive the next
//              stage's en with it when cascading
//   wrap     : registered one-cycle pulse, the previous edge wrapped
//   load_err : registered one-cycle pulse, the previous edge rejected a load
// -----------------------------------------------------------------------------
module modn_updown_counter #(
   parameter int MODULUS   = 5,
   parameter int WIDTH     = 3,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] d_out,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   // Reject illegal parameter sets at elaboration.
   if (MODULUS < 2 || (2 ** WIDTH) < MODULUS ||
       RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_params
      $error("modn_updown_counter: illegal MODULUS/WIDTH/RESET_VAL");
   end

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   // MODULUS may equal 2**WIDTH, so compare one bit wider.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic             at_max;
   logic             at_zero;
   logic             load_ok;
   logic [WIDTH-1:0] d_nxt;
   logic             wrap_nxt;
   logic             lerr_nxt;

   assign at_max  = (d_out == MAX_VAL);
   assign at_zero = (d_out == '0);
   assign load_ok = ({1'b0, load_val} < MOD_EXT);

   // Carry-out is suppressed whenever reset or load will override counting,
   // so a downstream stage never steps on a cycle this stage does not.
   assign tc = en & ~load & ~reset & (up_dn ? at_max : at_zero);

   always_comb begin
      d_nxt    = d_out;
      wrap_nxt = 1'b0;
      lerr_nxt = 1'b0;
      if (load) begin
         if (load_ok) d_nxt    = load_val;
         else         lerr_nxt = 1'b1;
      end else if (en) begin
         if (up_dn) begin
            d_nxt    = at_max ? '0 : d_out + ONE;
            wrap_nxt = at_max;
         end else begin
            d_nxt    = at_zero ? MAX_VAL : d_out - ONE;
            wrap_nxt = at_zero;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         d_out    <= RST_VAL;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         d_out    <= d_nxt;
         wrap     <= wrap_nxt;
         load_err <= lerr_nxt;
      end
   end

endmodule

// File: tb/tb_modn_updown_counter.sv
// Self-checking bench for modn_updown_counter: table of vectors on the default
// N=5/W=3 instance, plus cascade (two N=10 stages) and N=8 full-range runs.
module tb_modn_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- default instance N=5 W=3 ----------------
   logic       reset, en, up_dn, load;
   logic [2:0] load_val;
   logic [2:0] d_out;
   logic       tc, wrap, load_err;

   modn_updown_counter #(.MODULUS(5), .WIDTH(3), .RESET_VAL(0)) dut (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .d_out(d_out), .tc(tc), .wrap(wrap),
      .load_err(load_err)
   );

   // ---------------- cascade N=10 W=4 ----------------
   logic       c_rst, c_en;
   logic [3:0] c0_d, c1_d;
   logic       c0_tc, c1_tc, c0_wrap, c1_wrap, c0_le, c1_le;

   modn_updown_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(0)) u_c0 (
      .clk(clk), .reset(c_rst), .en(c_en), .up_dn(1'b1), .load(1'b0),
      .load_val(4'd0), .d_out(c0_d), .tc(c0_tc), .wrap(c0_wrap),
      .load_err(c0_le)
   );
   modn_updown_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(0)) u_c1 (
      .clk(clk), .reset(c_rst), .en(c0_tc), .up_dn(1'b1), .load(1'b0),
      .load_val(4'd0), .d_out(c1_d), .tc(c1_tc), .wrap(c1_wrap),
      .load_err(c1_le)
   );

   // ---------------- full-range N=8 W=3 ----------------
   logic       f_rst, f_en, f_up;
   logic [2:0] f_d;
   logic       f_tc, f_wrap, f_le;

   modn_updown_counter #(.MODULUS(8), .WIDTH(3), .RESET_VAL(0)) u_f (
      .clk(clk), .reset(f_rst), .en(f_en), .up_dn(f_up), .load(1'b0),
      .load_val(3'd0), .d_out(f_d), .tc(f_tc), .wrap(f_wrap),
      .load_err(f_le)
   );

   // ---------------- vector table + scoreboard ----------------
   typedef struct {
      logic       rst, en, up, ld;
      logic [2:0] lv;
      logic       exp_tc;     // tc before the edge
      logic [2:0] exp_d;      // after the edge
      logic       exp_wrap, exp_lerr;
      string      name;
   } vec_t;

   typedef struct {
      logic [2:0] d;
      logic       w, le;
      string      name;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   function automatic void add(input logic r, e, u, l, input int lv,
                               input logic t, input int d,
                               input logic w, le, input string name);
      vec_t v;
      v.rst = r; v.en = e; v.up = u; v.ld = l; v.lv = 3'(lv);
      v.exp_tc = t; v.exp_d = 3'(d); v.exp_wrap = w; v.exp_lerr = le;
      v.name = name;
      tbl.push_back(v);
   endfunction

   task automatic apply(input vec_t v);
      exp_t e, got;
      @(negedge clk);
      reset = v.rst; en = v.en; up_dn = v.up; load = v.ld; load_val = v.lv;
      #1;
      chk({v.name, ".tc"}, int'(tc), int'(v.exp_tc));
      e.d = v.exp_d; e.w = v.exp_wrap; e.le = v.exp_lerr; e.name = v.name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk({got.name, ".d"},    int'(d_out),    int'(got.d));
      chk({got.name, ".wrap"}, int'(wrap),     int'(got.w));
      chk({got.name, ".lerr"}, int'(load_err), int'(got.le));
   endtask

   int c1_wraps;
   int c0_wraps;

   initial begin
      reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
      c_rst = 1'b1; c_en = 1'b0;
      f_rst = 1'b1; f_en = 1'b0; f_up = 1'b1;

      //    rst en up ld lv  tc  d  w le
      // 1: reset two cycles, then count up through two wraps
      add(1, 1, 1, 0, 0, 0, 0, 0, 0, "rst0");
      add(1, 1, 1, 0, 0, 0, 0, 0, 0, "rst1");
      add(0, 1, 1, 0, 0, 0, 1, 0, 0, "up0");
      add(0, 1, 1, 0, 0, 0, 2, 0, 0, "up1");
      add(0, 1, 1, 0, 0, 0, 3, 0, 0, "up2");
      add(0, 1, 1, 0, 0, 0, 4, 0, 0, "up3");
      add(0, 1, 1, 0, 0, 1, 0, 1, 0, "up4wrap");
      add(0, 1, 1, 0, 0, 0, 1, 0, 0, "up5");
      add(0, 1, 1, 0, 0, 0, 2, 0, 0, "up6");
      add(0, 1, 1, 0, 0, 0, 3, 0, 0, "up7");
      add(0, 1, 1, 0, 0, 0, 4, 0, 0, "up8");
      add(0, 1, 1, 0, 0, 1, 0, 1, 0, "up9wrap");
      add(0, 1, 1, 0, 0, 0, 1, 0, 0, "up10");
      // 2: down count
      add(1, 1, 0, 0, 0, 0, 0, 0, 0, "rst_dn");
      add(0, 1, 0, 0, 0, 1, 4, 1, 0, "dn0wrap");
      add(0, 1, 0, 0, 0, 0, 3, 0, 0, "dn1");
      add(0, 1, 0, 0, 0, 0, 2, 0, 0, "dn2");
      add(0, 1, 0, 0, 0, 0, 1, 0, 0, "dn3");
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, "dn4");
      add(0, 1, 0, 0, 0, 1, 4, 1, 0, "dn5wrap");
      // 3: load legal / illegal
      add(1, 0, 1, 0, 0, 0, 0, 0, 0, "rst_ld");
      add(0, 1, 1, 0, 0, 0, 1, 0, 0, "ldup0");
      add(0, 1, 1, 0, 0, 0, 2, 0, 0, "ldup1");
      add(0, 0, 1, 1, 3, 0, 3, 0, 0, "ld3");
      add(0, 0, 1, 1, 6, 0, 3, 0, 1, "ld6_err");
      add(0, 0, 1, 0, 0, 0, 3, 0, 0, "ld_err_clr");
      add(0, 0, 1, 1, 5, 0, 3, 0, 1, "ld5_err");
      add(0, 0, 1, 1, 4, 0, 4, 0, 0, "ld4_max");
      // 4: priority
      add(0, 1, 1, 1, 1, 0, 1, 0, 0, "ld_over_en");
      add(0, 1, 1, 1, 4, 0, 4, 0, 0, "ld4b");
      add(1, 1, 1, 1, 4, 0, 0, 0, 0, "rst_over_ld");
      add(0, 1, 1, 0, 0, 0, 1, 0, 0, "mid0");
      add(0, 1, 1, 0, 0, 0, 2, 0, 0, "mid1");
      add(0, 1, 1, 0, 0, 0, 3, 0, 0, "mid2");
      add(1, 1, 1, 0, 0, 0, 0, 0, 0, "rst_mid");
      // 5: enable gating and reversal
      add(0, 1, 1, 0, 0, 0, 1, 0, 0, "g_en1");
      add(0, 0, 1, 0, 0, 0, 1, 0, 0, "g_en0");
      add(0, 1, 1, 0, 0, 0, 2, 0, 0, "g_en1b");
      add(0, 0, 1, 0, 0, 0, 2, 0, 0, "g_en0b");
      add(0, 1, 1, 0, 0, 0, 3, 0, 0, "g_up3");
      add(0, 1, 1, 0, 0, 0, 4, 0, 0, "g_up4");
      add(0, 0, 1, 0, 0, 0, 4, 0, 0, "g_hold4");
      add(0, 1, 0, 0, 0, 0, 3, 0, 0, "rev_dn");
      add(0, 1, 1, 0, 0, 0, 4, 0, 0, "rev_up");

      foreach (tbl[i]) apply(tbl[i]);
      chk("sb_empty", sb.size(), 0);

      // 6a: cascade of two N=10 stages, 100 enabled cycles
      @(negedge clk); c_rst = 1'b1; c_en = 1'b0;
      @(negedge clk);
      @(negedge clk); c_rst = 1'b0; c_en = 1'b1;
      c1_wraps = 0; c0_wraps = 0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); #1;
         if (c1_wrap) c1_wraps++;
         if (c0_wrap) c0_wraps++;
         if (n == 9)  chk("c0_tc_at9", int'(c0_tc), 1);
         if (n == 10) chk("c0_at10", int'(c0_d), 0);
         if (n == 10) chk("c1_at10", int'(c1_d), 1);
         if (n == 55) chk("c0_at55", int'(c0_d), 5);
         if (n == 55) chk("c1_at55", int'(c1_d), 5);
         if (n == 99) chk("c1_tc_at99", int'(c1_tc), 1);
      end
      chk("c0_final", int'(c0_d), 0);
      chk("c1_final", int'(c1_d), 0);
      chk("c1_wrap_now", int'(c1_wrap), 1);
      chk("c1_wraps", c1_wraps, 1);
      chk("c0_wraps", c0_wraps, 10);
      @(negedge clk); c_en = 1'b0;

      // 6b: N=8 natural binary wrap, up then down
      @(negedge clk); f_rst = 1'b1;
      @(negedge clk); f_rst = 1'b0; f_en = 1'b1; f_up = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         @(posedge clk); #1;
         chk("f_up", int'(f_d), n);
      end
      chk("f_tc7", int'(f_tc), 1);
      @(posedge clk); #1;
      chk("f_wrap_d", int'(f_d), 0);
      chk("f_wrap", int'(f_wrap), 1);
      @(negedge clk); f_up = 1'b0;
      #1 chk("f_tc0dn", int'(f_tc), 1);
      @(posedge clk); #1;
      chk("f_dn_d", int'(f_d), 7);
      chk("f_dn_wrap", int'(f_wrap), 1);
      @(negedge clk); f_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/modn_updown_counter.md
Name: modn_updown_counter

Overview:
Parametrised modulo-N counter. It generalises the team's fixed mod-5 counter to any modulus, and adds up/down direction, count enable, synchronous parallel load and cascade-ready terminal-count/wrap status. It is used as the standard sequencing counter for dividers, slot counters and cascaded multi-digit counters.

Parameters:
MODULUS, 5, count modulus N; legal range 2..2**WIDTH; count sequence spans 0..N-1
WIDTH, 3, bit width of count and load value; must satisfy 2**WIDTH >= MODULUS
RESET_VAL, 0, value d_out takes on reset; must be < MODULUS

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable; 1 = advance one step this cycle
up_dn  input  1  direction; 1 = count up, 0 = count down
load  input  1  synchronous load request
load_val  input  WIDTH  value written on load
d_out  output  WIDTH  current count, registered
tc  output  1  terminal count / carry-out, combinational
wrap  output  1  one-cycle registered pulse marking that a wrap occurred on the previous edge
load_err  output  1  one-cycle registered pulse marking that an illegal load was rejected

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset, sampled only on the rising edge of clk.
- Priority at each rising edge: reset > load > en > hold.
- Reset: d_out = RESET_VAL, wrap = 0, load_err = 0. Reset asserted mid-count takes effect on the next edge, regardless of load/en.
- Load (load=1, reset=0):
  - load_val < MODULUS: d_out <= load_val; wrap <= 0; load_err <= 0.
  - load_val >= MODULUS: d_out holds; load_err <= 1 for exactly one cycle; wrap <= 0.
  - Load ignores en and up_dn.
- Count (en=1, load=0, reset=0):
  - up_dn=1: d_out <= (d_out == MODULUS-1) ? 0 : d_out+1.
  - up_dn=0: d_out <= (d_out == 0) ? MODULUS-1 : d_out-1.
  - wrap <= 1 on the edge where the wrap transition occurs (MODULUS-1->0 up, 0->MODULUS-1 down), else 0.
- Hold (en=0, load=0): d_out unchanged; wrap <= 0; load_err <= 0.
- tc (combinational): en & ((up_dn & d_out==MODULUS-1) | (~up_dn & d_out==0)).
  - tc is the carry-out for cascading: drive the next stage's en with tc.
  - tc is 0 whenever load=1 or reset=1.
- Direction may change on any cycle. The new up_dn applies to the same edge, with no dead cycle.
- Counting is never saturating. All arithmetic is WIDTH bits and never produces a value >= MODULUS.
- Output latency:
  - d_out updates 1 cycle after en/load sampled.
  - wrap and load_err assert coincident with the updated d_out (same edge).
- MODULUS == 2**WIDTH must work (natural binary wrap). A MODULUS of 2**WIDTH-1 or less must never expose an out-of-range d_out, including after reset.
- Elaboration check: flag an error if MODULUS < 2, 2**WIDTH < MODULUS, or RESET_VAL >= MODULUS.

Test Plan:
1. Defaults (N=5, W=3). Reset high 2 cycles, then en=1, up_dn=1 for 12 cycles. Required: d_out 0,1,2,3,4,0,1,2,3,4,0,1. wrap pulses on the edges producing 0. tc=1 exactly while d_out=4.
2. Down count: reset, en=1, up_dn=0. Required: d_out 0,4,3,2,1,0,4. wrap pulses when 0->4. tc=1 while d_out=0.
3. Load: at d_out=2, load=1, load_val=3 -> d_out=3 next cycle, no wrap. Then load_val=6 -> d_out stays 3, load_err=1 for one cycle only.
4. Mixed control:
   - load=1 and en=1 with load_val=1 -> d_out=1 (load wins).
   - reset=1 with load=1, load_val=4 -> d_out=0.
   - reset asserted at d_out=3 mid-count -> d_out=0 next edge.
5. Enable gating and reversal: en toggles 1,0,1,0 while counting up from 0. Required: d_out 1,1,2,2, tc=0 while en=0. Then at d_out=4 with up_dn switched to 0 -> d_out=3, no wrap.
6. Cascade and full range:
   - Two instances (N=10, W=4), stage1.en = stage0.tc. After 100 enabled cycles from reset, both read 0 and stage1 wrap pulses once.
   - Separately, N=8, W=3 up-count wraps 7->0 with wrap=1.
